stopwatch_control_unit: RTL and testbench

Control FSM that sequences the stopwatch datapath: merges single-cycle button pulses with UART command bytes and drives the datapath's mode, run/stop and clear controls. The block monitors the datapath time outputs to stop a down-count automatically at zero. It sits between the button debouncers / UART receiver and the stopwatch datapath.

---
 rtl/stopwatch_control_unit.sv | 117 +++++++++++
 tb/tb_stopwatch_control_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_control_unit.sv
// Stopwatch control FSM: merges button pulses and UART commands into run/clear/mode controls.
// Optional lap snapshot capture is enabled with the STOPWATCH_LAP_EN macro.
module stopwatch_control_unit #(
  parameter logic [7:0] CMD_RUN   = 8'h52,
  parameter logic [7:0] CMD_CLEAR = 8'h43,
  parameter logic [7:0] CMD_MODE  = 8'h4D,
  parameter logic [7:0] CMD_LAP   = 8'h4C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_run_stop,
  input  logic       i_btn_clear,
  input  logic       i_btn_mode,
  input  logic       i_btn_lap,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  output logic       o_mode,
  output logic       o_run_stop,
  output logic       o_clear,
  output logic [1:0] o_state,
  output logic [6:0] o_lap_msec,
  output logic [5:0] o_lap_sec,
  output logic [5:0] o_lap_min,
  output logic [4:0] o_lap_hour,
  output logic       o_lap_valid
);

  typedef enum logic [1:0] {
    STOP  = 2'b00,
    RUN   = 2'b01,
    CLEAR = 2'b10
  } state_t;

  state_t state, state_nx;
  logic   mode, mode_nx;
  logic   zero, zero_q;
  logic   ev_run, ev_clear, ev_mode, ev_lap;
  logic   auto_stop;

  assign ev_run   = i_btn_run_stop | (i_rx_valid & (i_rx_data == CMD_RUN));
  assign ev_clear = i_btn_clear    | (i_rx_valid & (i_rx_data == CMD_CLEAR));
  assign ev_mode  = i_btn_mode     | (i_rx_valid & (i_rx_data == CMD_MODE));
  assign ev_lap   = i_btn_lap      | (i_rx_valid & (i_rx_data == CMD_LAP));

  assign zero = ({i_msec, i_sec, i_min, i_hour} == 24'd0);

  // Only the nonzero->zero edge stops a down-count
  assign auto_stop = mode & zero & ~zero_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= STOP;
      mode   <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      state  <= state_nx;
      mode   <= mode_nx;
      zero_q <= zero;
    end
  end

  always_comb begin
    state_nx = state;
    mode_nx  = mode;
    unique case (state)
      STOP: begin
        if (ev_run) begin
          if (!(mode && zero)) state_nx = RUN;
        end else if (ev_clear) begin
          state_nx = CLEAR;
        end else if (ev_mode) begin
          mode_nx = ~mode;
        end
      end
      RUN: begin
        if (ev_run || auto_stop) state_nx = STOP;
      end
      CLEAR: state_nx = STOP;
      default: state_nx = STOP;
    endcase
  end

  assign o_mode     = mode;
  assign o_state    = state;
  assign o_run_stop = (state == RUN);
  assign o_clear    = (state == CLEAR);

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk) begin
    if (!reset || state == CLEAR) begin
      o_lap_msec  <= '0;
      o_lap_sec   <= '0;
      o_lap_min   <= '0;
      o_lap_hour  <= '0;
      o_lap_valid <= 1'b0;
    end else if (state == RUN && ev_lap) begin
      o_lap_msec  <= i_msec;
      o_lap_sec   <= i_sec;
      o_lap_min   <= i_min;
      o_lap_hour  <= i_hour;
      o_lap_valid <= 1'b1;
    end
  end
`else
  assign o_lap_msec  = '0;
  assign o_lap_sec   = '0;
  assign o_lap_min   = '0;
  assign o_lap_hour  = '0;
  // Lap decode is masked off so the event has no effect
  assign o_lap_valid = ev_lap & 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_control_unit.sv
// Scoreboard bench for stopwatch_control_unit: random and directed stimulus
// checked against a behavioural model of the stopwatch controls.
module tb_stopwatch_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_run, btn_clr, btn_mode, btn_lap;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       o_mode, o_run_stop, o_clear, o_lap_valid;
  logic [1:0] o_state;
  logic [6:0] o_lap_msec;
  logic [5:0] o_lap_sec, o_lap_min;
  logic [4:0] o_lap_hour;

  stopwatch_control_unit dut (
    .clk(clk), .reset(reset),
    .i_btn_run_stop(btn_run), .i_btn_clear(btn_clr),
    .i_btn_mode(btn_mode), .i_btn_lap(btn_lap),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_msec(msec), .i_sec(sec), .i_min(min), .i_hour(hour),
    .o_mode(o_mode), .o_run_stop(o_run_stop), .o_clear(o_clear),
    .o_state(o_state),
    .o_lap_msec(o_lap_msec), .o_lap_sec(o_lap_sec),
    .o_lap_min(o_lap_min), .o_lap_hour(o_lap_hour),
    .o_lap_valid(o_lap_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [4:0] ctl;
    logic [24:0] lap;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: what the stopwatch is doing, in plain terms
  bit         m_running, m_clearing, m_down, m_was_zero;
  bit         m_lap_ok;
  logic [24:0] m_lap;

  function automatic void model(
    input bit rst_n, input bit r, input bit c, input bit m, input bit l,
    input logic [23:0] t
  );
    bit at_zero;
    at_zero = (t == 24'd0);
    if (!rst_n) begin
      m_running = 0; m_clearing = 0; m_down = 0; m_was_zero = 1;
      m_lap = '0; m_lap_ok = 0;
      return;
    end
    if (m_clearing) begin
      m_clearing = 0;
      m_lap = '0;
      m_lap_ok = 0;
    end else if (m_running) begin
      if (r) m_running = 0;
      else if (m_down && at_zero && !m_was_zero) m_running = 0;
`ifdef STOPWATCH_LAP_EN
      if (l) begin
        m_lap = {t, 1'b1};
        m_lap_ok = 1;
      end
`endif
    end else begin
      if (r) m_running = !(m_down && at_zero);
      else if (c) m_clearing = 1;
      else if (m) m_down = !m_down;
    end
    m_was_zero = at_zero;
  endfunction

  task automatic step(
    input bit rst_n, input bit b_r, input bit b_c, input bit b_m,
    input bit b_l, input bit v, input logic [7:0] d,
    input logic [6:0] ms, input logic [5:0] s,
    input logic [5:0] mi, input logic [4:0] h
  );
    exp_t e;
    bit r, c, m, l;
    reset = rst_n; btn_run = b_r; btn_clr = b_c; btn_mode = b_m;
    btn_lap = b_l; rx_valid = v; rx_data = d;
    msec = ms; sec = s; min = mi; hour = h;
    r = b_r | (v && d == 8'h52);
    c = b_c | (v && d == 8'h43);
    m = b_m | (v && d == 8'h4D);
    l = b_l | (v && d == 8'h4C);
    model(rst_n, r, c, m, l, {ms, s, mi, h});
    e.due = cyc + 1;
    e.ctl = {m_clearing ? 2'b10 : (m_running ? 2'b01 : 2'b00),
             m_running, m_clearing, m_down};
    e.lap = m_lap_ok ? m_lap : 25'd0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [6:0] ms, input logic [5:0] s,
                      input logic [5:0] mi, input logic [4:0] h);
    step(1, 0, 0, 0, 0, 0, 8'h00, ms, s, mi, h);
  endtask

  task automatic cmd(input logic [7:0] d, input logic [6:0] ms,
                     input logic [5:0] s, input logic [5:0] mi,
                     input logic [4:0] h);
    step(1, 0, 0, 0, 0, 1, d, ms, s, mi, h);
  endtask

  initial begin : monitor
    exp_t e;
    logic [4:0] got_ctl;
    logic [24:0] got_lap;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        got_ctl = {o_state, o_run_stop, o_clear, o_mode};
        got_lap = {o_lap_msec, o_lap_sec, o_lap_min, o_lap_hour, o_lap_valid};
        vectors++;
        if (got_ctl !== e.ctl) begin
          miscompares++;
          $display("FAIL ctl cyc=%0d got state/run/clr/mode=%b want %b",
                   cyc, got_ctl, e.ctl);
        end
        if (got_lap !== e.lap) begin
          miscompares++;
          $display("FAIL lap cyc=%0d got %h want %h", cyc, got_lap, e.lap);
        end
      end
    end
  end

  initial begin : driver
    logic [7:0] d;
    logic [6:0] ms;
    logic [5:0] s, mi;
    logic [4:0] h;
    int sel;
    reset = 0; btn_run = 0; btn_clr = 0; btn_mode = 0; btn_lap = 0;
    rx_valid = 0; rx_data = 0; msec = 0; sec = 0; min = 0; hour = 0;
    @(posedge clk);
    #1;
    // 1: reset then run/stop toggles
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    idle(6, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0);
    idle(7, 0, 0, 0);
    // 2: clear in STOP, clear ignored in RUN
    cmd(8'h43, 7, 0, 0, 0);
    idle(0, 0, 0, 0);
    idle(0, 0, 0, 0);
    cmd(8'h52, 0, 0, 0, 0);
    cmd(8'h43, 1, 0, 0, 0);
    idle(2, 0, 0, 0);
    cmd(8'h52, 2, 0, 0, 0);
    // 3: same-cycle merges and priority
    step(1, 1, 0, 0, 0, 1, 8'h52, 2, 0, 0, 0);
    idle(3, 0, 0, 0);
    cmd(8'h52, 3, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 3, 0, 0, 0);
    idle(4, 0, 0, 0);
    cmd(8'h52, 4, 0, 0, 0);
    // 4: down-count auto-stop, then blocked start at zero
    cmd(8'h4D, 4, 0, 0, 0);
    cmd(8'h52, 1, 0, 0, 0);
    idle(1, 0, 0, 0);
    idle(0, 0, 0, 0);
    idle(0, 0, 0, 0);
    cmd(8'h52, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    // 5: lap capture at 00:01:23.45
    cmd(8'h4D, 0, 0, 0, 0);
    cmd(8'h52, 45, 23, 1, 0);
    cmd(8'h4C, 45, 23, 1, 0);
    idle(46, 23, 1, 0);
    cmd(8'h52, 47, 23, 1, 0);
    step(1, 0, 0, 0, 1, 0, 0, 50, 30, 2, 0);
    cmd(8'h43, 50, 30, 2, 0);
    idle(0, 0, 0, 0);
    idle(0, 0, 0, 0);
    // 6: reset in RUN, reset in CLEAR
    cmd(8'h4D, 9, 0, 0, 0);
    cmd(8'h52, 9, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0);
    idle(9, 0, 0, 0);
    cmd(8'h43, 9, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0);
    idle(9, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      case ($urandom_range(0, 5))
        0: d = 8'h52;
        1: d = 8'h43;
        2: d = 8'h4D;
        3: d = 8'h4C;
        default: d = 8'($urandom);
      endcase
      if (sel < 4) begin
        ms = 0; s = 0; mi = 0; h = 0;
      end else if (sel < 7) begin
        ms = 7'($urandom_range(0, 2)); s = 0; mi = 0; h = 0;
      end else begin
        ms = 7'($urandom); s = 6'($urandom);
        mi = 6'($urandom); h = 5'($urandom);
      end
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0, d, ms, s, mi, h);
    end
    idle(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
